dbus_responder: RTL and testbench

DBUS_RESPONDER -- requirements
Module: dbus_responder

---
 rtl/dbus_responder.sv | 119 +++++++++++
 tb/tb_dbus_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_responder.sv
// Single-port data-bus responder backed by a 64-bit word array.
// Accepts one request at a time and answers after a fixed, parameterised latency.

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_responder
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [64:0] LIMIT    = {1'b0, BASE} + 65'(DEPTH) * 65'd8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [63:0] addr_q;
  logic [7:0]  strobe_q;
  logic [63:0] data_q;
  logic [63:0] mem_q [DEPTH];

  logic [63:0]   offset;
  logic [AW-1:0] idx;
  logic          oor;
  logic          fire;

  assign offset = addr_q - BASE;
  assign idx    = offset[AW+2:3];
  assign oor    = (addr_q < BASE) || ({1'b0, addr_q} >= LIMIT);
  // The initiator must hold valid through the response; dropping it aborts.
  assign fire   = (state_q == RESP) && dreq.valid;

  // NOTE: every register here is written with <= so all state updates
  // see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dreq.valid) begin
            addr_q   <= dreq.addr;
            strobe_q <= dreq.strobe;
            data_q   <= dreq.data;
            cnt_q    <= CNT_LOAD;
            state_q  <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (!dreq.valid) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q < 4'd2) state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset branch; clearing a RAM would need a
  // multi-cycle sweep and contents are defined as uninitialised anyway.
  always_ff @(posedge clk) begin
    if (fire && !oor) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem_q[idx][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

  // NOTE: outputs get a full default first so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = reset && (state_q == IDLE) && dreq.valid;
    dresp.data_ok = fire;
    err           = fire && oor;
    if (fire && !oor && (strobe_q == 8'h00)) dresp.data = mem_q[idx];
  end

  logic unused_ok;
  assign unused_ok = ^dreq.size;

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder: transaction-level model checked every
// cycle on the LATENCY=2 instance, plus directed literal checks on both instances.
`timescale 1ns/1ps
module tb_dbus_responder;
  import dbus_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  dbus_req_t  dreq, dreq1;
  dbus_resp_t dresp, dresp1;
  logic       err, err1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE(BASE)) u_dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .err(err)
  );

  dbus_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE(BASE)) u_dut1 (
    .clk(clk), .reset(reset), .dreq(dreq1), .dresp(dresp1), .err(err1)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of the LATENCY=2 instance ----------------
  logic [63:0] mem_m [longint unsigned];
  bit          m_active = 1'b0;
  int          m_elapsed = 0;
  dbus_req_t   m_req;
  logic [63:0] m_w;
  longint unsigned m_k;
  logic        e_ao, e_do, e_er;
  logic [63:0] e_d;

  function automatic bit in_range(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
  endfunction

  function automatic longint unsigned widx(input logic [63:0] a);
    return longint'((a - BASE) >> 3);
  endfunction

  // Transaction progress: cycles elapsed since the accepting edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (dreq.valid) begin
        m_active  = 1'b1;
        m_elapsed = 1;
        m_req     = dreq;
      end
    end else if (!dreq.valid) begin
      m_active = 1'b0;
    end else if (m_elapsed == int'(LAT)) begin
      if (in_range(m_req.addr) && m_req.strobe != 8'h00) begin
        m_k = widx(m_req.addr);
        m_w = mem_m.exists(m_k) ? mem_m[m_k] : 64'h0;
        for (int b = 0; b < 8; b++)
          if (m_req.strobe[b]) m_w[8*b +: 8] = m_req.data[8*b +: 8];
        mem_m[m_k] = m_w;
      end
      m_active = 1'b0;
    end else begin
      m_elapsed++;
    end
  end

  always @(negedge clk) begin
    e_ao = 1'b0; e_do = 1'b0; e_er = 1'b0; e_d = 64'h0;
    if (reset) begin
      if (!m_active) begin
        e_ao = dreq.valid;
      end else if (dreq.valid && m_elapsed == int'(LAT)) begin
        e_do = 1'b1;
        if (!in_range(m_req.addr)) e_er = 1'b1;
        else if (m_req.strobe == 8'h00) e_d = mem_m[widx(m_req.addr)];
      end
    end
    check($sformatf("cycle%0d", cyc), {dresp.addr_ok, dresp.data_ok, err, dresp.data},
          {e_ao, e_do, e_er, e_d});
  end

  // ---------------- directed stimulus ----------------
  task automatic txn(input bit rel, input logic [63:0] a, input logic [7:0] s,
                     input logic [63:0] d, output logic [63:0] rd, output logic er,
                     output int acc_wait, output int lat);
    int t0;
    bit got;
    rd = 64'h0; er = 1'b0; acc_wait = -1; lat = -1;
    @(posedge clk); #1;
    if (rel) reset = 1'b1;
    dreq = '{valid: 1'b1, addr: a, size: 3'd3, strobe: s, data: d};
    t0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dresp.addr_ok) begin got = 1'b1; acc_wait = cyc - t0; end
    end
    if (got) begin
      t0  = cyc;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (dresp.data_ok) begin
          got = 1'b1; lat = cyc - t0; rd = dresp.data; er = err;
        end
      end
    end
    @(posedge clk); #1;
    dreq = '0;
  endtask

  task automatic rw(input string name, input bit rel, input logic [63:0] a,
                    input logic [7:0] s, input logic [63:0] d,
                    input logic [63:0] exp_d, input logic exp_e);
    logic [63:0] rd;
    logic        er;
    int          aw, lt;
    txn(rel, a, s, d, rd, er, aw, lt);
    check({name, "_accept"}, aw, 0);
    check({name, "_latency"}, lt, LAT);
    check({name, "_resp"}, {er, rd}, {exp_e, exp_d});
  endtask

  logic [5:0]  ao_pat = 6'b010101;
  logic [63:0] d1     = 64'h0F1E_2D3C_4B5A_6978;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, at %0t", $time);
    $fatal(1);
  end

  initial begin
    dreq  = '{valid: 1'b1, addr: 64'h8000_0008, size: 3'd3, strobe: 8'hFF,
              data: 64'h0102_0304_0506_0708};
    dreq1 = '0;
    #2;
    check("reset_out", {dresp.addr_ok, dresp.data_ok, err, dresp.data}, 67'h0);
    check("reset_out1", {dresp1.addr_ok, dresp1.data_ok, err1, dresp1.data}, 67'h0);
    repeat (2) @(negedge clk);

    rw("first_after_reset", 1'b1, 64'h8000_0008, 8'hFF, 64'h0102_0304_0506_0708, 64'h0, 1'b0);
    rw("wr_full",  1'b0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 1'b0);
    rw("rd_full",  1'b0, 64'h8000_0010, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b0);
    rw("wr_strb",  1'b0, 64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 64'h0, 1'b0);
    rw("rd_strb",  1'b0, 64'h8000_0017, 8'h00, 64'h0, 64'h1122_3344_BBBB_BBBB, 1'b0);
    rw("wr_word0", 1'b0, 64'h8000_0000, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'h0, 1'b0);
    rw("rd_below", 1'b0, 64'h7FFF_FFF8, 8'h00, 64'h0, 64'h0, 1'b1);
    rw("wr_above", 1'b0, 64'h8000_2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    rw("wr_last",  1'b0, 64'h8000_1FF8, 8'hFF, 64'h0BAD_C0DE_0000_0001, 64'h0, 1'b0);
    rw("rd_last",  1'b0, 64'h8000_1FF8, 8'h00, 64'h0, 64'h0BAD_C0DE_0000_0001, 1'b0);
    rw("rd_word0", 1'b0, 64'h8000_0000, 8'h00, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0);
    rw("rd_word1", 1'b0, 64'h8000_0008, 8'h00, 64'h0, 64'h0102_0304_0506_0708, 1'b0);

    // Reset asserted in the BUSY cycle of a write.
    @(posedge clk); #1;
    dreq = '{valid: 1'b1, addr: 64'h8000_0000, size: 3'd3, strobe: 8'hFF, data: 64'hDEAD_DEAD_DEAD_DEAD};
    @(negedge clk);
    check("busy_rst_accept", dresp.addr_ok, 1'b1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("busy_rst_out", {dresp.addr_ok, dresp.data_ok, err, dresp.data}, 67'h0);
    @(posedge clk); #1;
    dreq = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    rw("rd_after_busy_rst", 1'b0, 64'h8000_0000, 8'h00, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0);

    // Reset asserted in the RESP cycle of a write, after data_ok is visible.
    @(posedge clk); #1;
    dreq = '{valid: 1'b1, addr: 64'h8000_0000, size: 3'd3, strobe: 8'hFF, data: 64'hDEAD_DEAD_DEAD_DEAD};
    repeat (3) @(negedge clk);
    check("resp_rst_before", dresp.data_ok, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("resp_rst_out", {dresp.addr_ok, dresp.data_ok, err, dresp.data}, 67'h0);
    @(posedge clk); #1;
    dreq = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    rw("rd_after_resp_rst", 1'b0, 64'h8000_0000, 8'h00, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0);

    // valid dropped in BUSY: aborted, next request accepted at once.
    @(posedge clk); #1;
    dreq = '{valid: 1'b1, addr: 64'h8000_0000, size: 3'd3, strobe: 8'hFF, data: 64'hDEAD_DEAD_DEAD_DEAD};
    @(negedge clk);
    check("drop_accept", dresp.addr_ok, 1'b1);
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    @(negedge clk);
    check("drop_no_data_ok", dresp.data_ok, 1'b0);
    rw("rd_after_drop", 1'b0, 64'h8000_0000, 8'h00, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0);

    // LATENCY=1 instance, valid held continuously: write then two reads.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c < 2) dreq1 = '{valid: 1'b1, addr: 64'h8000_0040, size: 3'd3, strobe: 8'hFF, data: d1};
      else       dreq1 = '{valid: 1'b1, addr: 64'h8000_0040, size: 3'd3, strobe: 8'h00, data: 64'h0};
      @(negedge clk);
      check($sformatf("b2b_c%0d", c), {dresp1.addr_ok, dresp1.data_ok, err1, dresp1.data},
            {ao_pat[c], ~ao_pat[c], 1'b0, (c == 3 || c == 5) ? d1 : 64'h0});
    end
    @(posedge clk); #1;
    dreq1 = '0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
